// File: rtl/reg_bus_reader.sv
// Read-side bus interface: on a four-phase request, captures one source register
// and drives it onto a shared, OR-combinable data bus for a fixed window.
module reg_bus_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREG  = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned HOLD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [SEL_W-1:0]        rd_sel,
  input  logic [NREG*WIDTH-1:0]   reg_in,
  output logic [WIDTH-1:0]        bus_data,
  output logic                    bus_oe,
  output logic                    rd_ack,
  output logic                    busy,
  output logic [WIDTH-1:0]        Dshow
);

  localparam int unsigned HOLD_EFF = (HOLD == 0) ? 1 : HOLD;
  localparam int unsigned CNT_W    = $clog2(HOLD_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t             state_q,    state_d;
  logic [SEL_W-1:0]   sel_q,      sel_d;
  logic [WIDTH-1:0]   latch_q,    latch_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   bus_data_q, bus_data_d;
  logic               bus_oe_q,   bus_oe_d;
  logic               rd_ack_q,   rd_ack_d;
  logic               busy_q,     busy_d;
  logic [WIDTH-1:0]   reg_pick_c;

  // Source register mux; an out-of-range index reads as zero.
  always_comb begin
    reg_pick_c = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (sel_q == SEL_W'(k)) begin
        reg_pick_c = reg_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    latch_d    = latch_q;
    cnt_d      = cnt_q;
    bus_data_d = bus_data_q;
    bus_oe_d   = bus_oe_q;
    rd_ack_d   = rd_ack_q;
    busy_d     = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          sel_d   = rd_sel;
          busy_d  = 1'b1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        latch_d    = reg_pick_c;
        bus_data_d = reg_pick_c;
        bus_oe_d   = 1'b1;
        cnt_d      = CNT_LOAD;
        state_d    = S_DRIVE;
      end
      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          bus_oe_d   = 1'b0;
          bus_data_d = '0;
          rd_ack_d   = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        // Hold the acknowledge until the requester releases its request.
        if (!rd_req) begin
          rd_ack_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      latch_q    <= '0;
      cnt_q      <= '0;
      bus_data_q <= '0;
      bus_oe_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      latch_q    <= latch_d;
      cnt_q      <= cnt_d;
      bus_data_q <= bus_data_d;
      bus_oe_q   <= bus_oe_d;
      rd_ack_q   <= rd_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign bus_data = bus_data_q;
  assign bus_oe   = bus_oe_q;
  assign rd_ack   = rd_ack_q;
  assign busy     = busy_q;
  assign Dshow    = latch_q;

endmodule

// File: tb/tb_reg_bus_reader.sv
// Bench for reg_bus_reader: default, HOLD=0 and NREG=3 builds run in lockstep
// against a cycle-offset reference model, with directed steps and random traffic.
module tb_reg_bus_reader;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic [1:0]  rd_sel;
  logic [31:0] reg_in;

  logic [7:0]  bd [3];
  logic        oe [3];
  logic        ack [3];
  logic        bsy [3];
  logic [7:0]  ds [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per instance, active flag, edges since acceptance, index, value.
  bit         act  [3];
  int         kcnt [3];
  int         msel [3];
  logic [7:0] mval [3];

  reg_bus_reader #(.WIDTH(8), .NREG(4), .SEL_W(2), .HOLD(2)) u_main (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_sel(rd_sel), .reg_in(reg_in),
    .bus_data(bd[0]), .bus_oe(oe[0]), .rd_ack(ack[0]), .busy(bsy[0]), .Dshow(ds[0])
  );

  reg_bus_reader #(.WIDTH(8), .NREG(4), .SEL_W(2), .HOLD(0)) u_hold0 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_sel(rd_sel), .reg_in(reg_in),
    .bus_data(bd[1]), .bus_oe(oe[1]), .rd_ack(ack[1]), .busy(bsy[1]), .Dshow(ds[1])
  );

  reg_bus_reader #(.WIDTH(8), .NREG(3), .SEL_W(2), .HOLD(2)) u_nreg3 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_sel(rd_sel), .reg_in(reg_in[23:0]),
    .bus_data(bd[2]), .bus_oe(oe[2]), .rd_ack(ack[2]), .busy(bsy[2]), .Dshow(ds[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hold_of(input int i);
    return (i == 1) ? 1 : 2;
  endfunction

  function automatic int nreg_of(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      act[i]  = 1'b0;
      kcnt[i] = 0;
      msel[i] = 0;
      mval[i] = 8'h00;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!act[i]) begin
        if (rd_req) begin
          act[i]  = 1'b1;
          kcnt[i] = 0;
          msel[i] = int'(rd_sel);
        end
      end else if (kcnt[i] >= hold_of(i) + 1) begin
        if (!rd_req) act[i] = 1'b0;
      end else begin
        kcnt[i]++;
        if (kcnt[i] == 1)
          mval[i] = (msel[i] < nreg_of(i)) ? reg_in[msel[i]*8 +: 8] : 8'h00;
      end
    end
  endtask

  task automatic check_all();
    logic exp_oe, exp_ack;
    for (int i = 0; i < 3; i++) begin
      exp_oe  = act[i] && (kcnt[i] >= 1) && (kcnt[i] <= hold_of(i));
      exp_ack = act[i] && (kcnt[i] == hold_of(i) + 1);
      chk("bus_oe",   i, 8'(oe[i]),  8'(exp_oe));
      chk("rd_ack",   i, 8'(ack[i]), 8'(exp_ack));
      chk("busy",     i, 8'(bsy[i]), 8'(act[i]));
      chk("bus_data", i, bd[i],      exp_oe ? mval[i] : 8'h00);
      chk("Dshow",    i, ds[i],      mval[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_all();
  endtask

  initial begin
    bit prev_req;

    // Asynchronous reset with random inputs, before any clock edge.
    rst    = 1'b1;
    rd_req = 1'($urandom);
    rd_sel = 2'($urandom);
    reg_in = $urandom;
    #1 rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_oe",   i, 8'(oe[i]),  8'h00);
      chk("rst_ack",  i, 8'(ack[i]), 8'h00);
      chk("rst_busy", i, 8'(bsy[i]), 8'h00);
      chk("rst_data", i, bd[i],      8'h00);
      chk("rst_dshow",i, ds[i],      8'h00);
    end
    @(negedge clk);
    rd_req = 1'b0;
    rst    = 1'b1;
    tick();

    // Basic read of register 2, then stability against input changes after capture.
    reg_in = 32'h4433_2211;
    rd_sel = 2'd2;
    rd_req = 1'b1;
    tick();
    chk("accept_busy", 0, 8'(bsy[0]), 8'h01);
    chk("accept_oe",   0, 8'(oe[0]),  8'h00);
    tick();
    chk("e1_oe",   0, 8'(oe[0]), 8'h01);
    chk("e1_data", 0, bd[0],     8'h33);
    chk("h0_oe",   1, 8'(oe[1]), 8'h01);
    reg_in[23:16] = 8'hAA;
    rd_sel = 2'd0;
    tick();
    chk("e2_oe",     0, 8'(oe[0]),  8'h01);
    chk("e2_data",   0, bd[0],      8'h33);
    chk("h0_ack_e2", 1, 8'(ack[1]), 8'h01);
    chk("h0_oe_e2",  1, 8'(oe[1]),  8'h00);
    tick();
    chk("e3_oe",    0, 8'(oe[0]),  8'h00);
    chk("e3_ack",   0, 8'(ack[0]), 8'h01);
    chk("e3_data",  0, bd[0],      8'h00);
    chk("e3_dshow", 0, ds[0],      8'h33);

    // Request held long after acknowledge: no second drive window.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_ack", 0, 8'(ack[0]), 8'h01);
      chk("hold_oe",  0, 8'(oe[0]),  8'h00);
    end
    rd_req = 1'b0;
    tick();
    chk("drop_ack",  0, 8'(ack[0]), 8'h00);
    chk("drop_busy", 0, 8'(bsy[0]), 8'h00);
    chk("drop_dshow",0, ds[0],      8'h33);

    // Re-raise with index 3; the three-register build must read zero.
    rd_sel = 2'd3;
    rd_req = 1'b1;
    tick();
    tick();
    chk("r3_data",  0, bd[0],     8'h44);
    chk("n3_oe",    2, 8'(oe[2]), 8'h01);
    chk("n3_data",  2, bd[2],     8'h00);
    tick();
    chk("r3_data2", 0, bd[0],     8'h44);
    tick();
    chk("r3_ack",   0, 8'(ack[0]), 8'h01);
    chk("n3_ack",   2, 8'(ack[2]), 8'h01);
    rd_req = 1'b0;
    tick();

    // Reset in the middle of the drive window, released with a pending request.
    rd_sel = 2'd1;
    rd_req = 1'b1;
    tick();
    tick();
    chk("pre_rst_oe", 0, 8'(oe[0]), 8'h01);
    #3 rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_oe",    0, 8'(oe[0]),  8'h00);
    chk("mid_rst_busy",  0, 8'(bsy[0]), 8'h00);
    chk("mid_rst_dshow", 0, ds[0],      8'h00);
    check_all();
    rd_sel = 2'd3;
    #2 rst = 1'b1;
    tick();
    chk("restart_busy", 0, 8'(bsy[0]), 8'h01);
    tick();
    tick();
    tick();
    chk("restart_ack",   0, 8'(ack[0]), 8'h01);
    chk("restart_dshow", 0, ds[0],      8'h44);
    rd_req = 1'b0;
    tick();

    // Random traffic: sticky request, per-cycle input churn, occasional async reset.
    prev_req = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) prev_req = ~prev_req;
      rd_req = prev_req;
      rd_sel = 2'($urandom);
      reg_in = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #3 rst = 1'b0;
        model_reset();
        #1 check_all();
        #2 rst = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
